dmem_arbiter: RTL and testbench

//  Two-port round-robin arbiter/sequencer for the single-port 64x32 data memory.

---
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 tb/tb_dmem_arbiter.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter/sequencer for a single-port data memory
//
// Purpose:
//   Arbitrates between port 0 (load/store unit) and port 1 (debug/DMA loader) for a
//   single-port memory with a combinational read path. A request is sampled in IDLE,
//   the winner's command is latched, and exactly one memory access is driven during the
//   single ACCESS cycle that follows. Reads return registered data with a one-cycle
//   valid pulse on the cycle after ACCESS.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   req0/1, we0/1          request and write-enable per port (held until grant)
//   addr0/1, wdata0/1      word address and write data per port
//   gnt0/1                 one-cycle grant pulse, asserted during ACCESS
//   rvalid0/1, rdata       one-cycle read-valid pulse and registered read data
//   mem_read, mem_write    memory strobes, mutually exclusive, only during ACCESS
//   mem_addr, mem_wdata    memory address and write data
//   mem_rdata              memory read data (combinational from mem_addr)

module dmem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t state;
    logic   ptr;     // port that wins the next tie
    logic   sel_q;   // port being served in ACCESS
    logic   we_q;    // latched direction of the access in flight

    logic              win_sel;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // A lone requester always wins; the pointer only matters on a tie.
    always_comb begin
        win_sel = ptr;
        if (req0 && !req1) begin
            win_sel = 1'b0;
        end else if (req1 && !req0) begin
            win_sel = 1'b1;
        end
        win_we    = win_sel ? we1    : we0;
        win_addr  = win_sel ? addr1  : addr0;
        win_wdata = win_sel ? wdata1 : wdata0;
    end

    // mem_addr/mem_wdata double as the latched address/data registers: they are
    // loaded with the winner's command on entry to ACCESS and cleared on exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            sel_q     <= 1'b0;
            we_q      <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata     <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            // Pulses and strobes default low; only the branches below raise them.
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;

            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state     <= ACCESS;
                        sel_q     <= win_sel;
                        we_q      <= win_we;
                        // Hand priority to the other port so contention alternates.
                        ptr       <= ~win_sel;
                        gnt0      <= ~win_sel;
                        gnt1      <= win_sel;
                        mem_write <= win_we;
                        mem_read  <= ~win_we;
                        mem_addr  <= win_addr;
                        mem_wdata <= win_we ? win_wdata : '0;
                    end
                end

                ACCESS: begin
                    state <= IDLE;
                    // Capture read data at the edge closing ACCESS; writes leave
                    // rdata untouched so the last read result stays visible.
                    if (!we_q) begin
                        rdata   <= mem_rdata;
                        rvalid0 <= ~sel_q;
                        rvalid1 <= sel_q;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with behavioural memory model

module tb_dmem_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // memory attached to the arbiter, plus a backdoor for preloading
    logic [DW-1:0] mem [0:63];
    logic          bd_clr = 1'b0, bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;

    // reference model state
    logic [DW-1:0] ref_mem [0:63];
    logic [DW-1:0] last_rdata;
    logic          last_win;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bd_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    assign mem_rdata = mem[mem_addr];

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic drive(input int p, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        last_win   = 1'b1;
        last_rdata = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bd_clr = 1'b1;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        @(negedge clk);
        bd_clr = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write});
        end
        n_cmp++;
        if ({rdata, mem_addr, mem_wdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h want 0",
                     rdata, mem_addr, mem_wdata);
        end
        rst = 1'b0;
        last_win   = 1'b1;
        last_rdata = '0;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 6'd2, 32'h12345678);
        @(negedge clk);
        n_cmp++;
        if ({gnt1, gnt0, mem_read, mem_write} !== 4'b0101) begin
            n_bad++;
            $display("FAIL wr_access: got gnt=%b rd/wr=%b want 01 01",
                     {gnt1, gnt0}, {mem_read, mem_write});
        end
        n_cmp++;
        if (mem_addr !== 6'd2 || mem_wdata !== 32'h12345678) begin
            n_bad++;
            $display("FAIL wr_cmd: got addr=%0d data=%h want 2 12345678", mem_addr, mem_wdata);
        end
        ref_mem[2] = 32'h12345678;
        @(negedge clk);
        n_cmp++;
        if ({gnt1, gnt0, mem_read, mem_write} !== 4'b0000) begin
            n_bad++;
            $display("FAIL wr_idle: got gnt=%b rd/wr=%b want 00 00",
                     {gnt1, gnt0}, {mem_read, mem_write});
        end
        drive(0, 1'b1, 1'b0, 6'd2, '0);
        @(negedge clk);
        n_cmp++;
        if ({gnt1, gnt0, mem_read, mem_write, mem_addr} !== {4'b0110, 6'd2}) begin
            n_bad++;
            $display("FAIL rd_access: got gnt=%b rd/wr=%b addr=%0d want 01 10 2",
                     {gnt1, gnt0}, {mem_read, mem_write}, mem_addr);
        end
        @(negedge clk);
        n_cmp++;
        if ({rvalid1, rvalid0} !== 2'b01 || rdata !== 32'h12345678) begin
            n_bad++;
            $display("FAIL rd_data: got rvalid=%b rdata=%h want 01 12345678",
                     {rvalid1, rvalid0}, rdata);
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        last_rdata = 32'h12345678;
        last_win   = 1'b0;
    endtask

    task automatic test_contention();
        logic [1:0]    exp_g;
        logic [1:0]    exp_rv;
        logic [DW-1:0] exp_d;
        apply_reset(1);
        bd_we = 1'b1; bd_addr = 6'd3; bd_data = 32'h87654321;
        ref_mem[3] = 32'h87654321;
        @(negedge clk);
        bd_we = 1'b0;
        drive(0, 1'b1, 1'b0, 6'd2, '0);
        drive(1, 1'b1, 1'b0, 6'd3, '0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            // grant k (k = 0,1,2,3) lands on odd cycles and alternates 0,1,0,1
            exp_g = 2'b00;
            if (i % 2 == 1) exp_g = (((i - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10;
            n_cmp++;
            if ({gnt1, gnt0} !== exp_g) begin
                n_bad++;
                $display("FAIL rr_gnt[%0d]: got %b want %b", i, {gnt1, gnt0}, exp_g);
            end
            if (i % 2 == 0) begin
                exp_rv = (((i / 2) - 1) % 2 == 0) ? 2'b01 : 2'b10;
                exp_d  = exp_rv[0] ? ref_mem[2] : ref_mem[3];
                n_cmp++;
                if ({rvalid1, rvalid0} !== exp_rv || rdata !== exp_d) begin
                    n_bad++;
                    $display("FAIL rr_rdata[%0d]: got rvalid=%b rdata=%h want %b %h",
                             i, {rvalid1, rvalid0}, rdata, exp_rv, exp_d);
                end
            end
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        last_rdata = ref_mem[3];
        last_win   = 1'b1;
    endtask

    task automatic test_port1_solo();
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 6'd63, 32'hDEADBEEF);
        @(negedge clk);
        n_cmp++;
        if ({gnt1, gnt0, mem_write, mem_addr, mem_wdata} !== {3'b101, 6'd63, 32'hDEADBEEF}) begin
            n_bad++;
            $display("FAIL p1_write: got gnt=%b wr=%b addr=%0d data=%h want 10 1 63 deadbeef",
                     {gnt1, gnt0}, mem_write, mem_addr, mem_wdata);
        end
        ref_mem[63] = 32'hDEADBEEF;
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 6'd63, '0);
        @(negedge clk);
        n_cmp++;
        if ({gnt1, gnt0, mem_read} !== 3'b101) begin
            n_bad++;
            $display("FAIL p1_read: got gnt=%b rd=%b want 10 1", {gnt1, gnt0}, mem_read);
        end
        @(negedge clk);
        n_cmp++;
        if ({rvalid1, rvalid0} !== 2'b10 || rdata !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL p1_rdata: got rvalid=%b rdata=%h want 10 deadbeef",
                     {rvalid1, rvalid0}, rdata);
        end
        // port 1 was served last, so port 0 must win the tie
        drive(0, 1'b1, 1'b0, 6'd3, '0);
        drive(1, 1'b1, 1'b0, 6'd2, '0);
        @(negedge clk);
        n_cmp++;
        if ({gnt1, gnt0} !== 2'b01) begin
            n_bad++;
            $display("FAIL tie_after_p1: got %b want 01", {gnt1, gnt0});
        end
        @(negedge clk);
        n_cmp++;
        if ({rvalid1, rvalid0} !== 2'b01 || rdata !== ref_mem[3]) begin
            n_bad++;
            $display("FAIL tie_rdata0: got rvalid=%b rdata=%h want 01 %h",
                     {rvalid1, rvalid0}, rdata, ref_mem[3]);
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        n_cmp++;
        if ({gnt1, gnt0} !== 2'b10) begin
            n_bad++;
            $display("FAIL tie_second: got %b want 10", {gnt1, gnt0});
        end
        @(negedge clk);
        n_cmp++;
        if ({rvalid1, rvalid0} !== 2'b10 || rdata !== ref_mem[2]) begin
            n_bad++;
            $display("FAIL tie_rdata1: got rvalid=%b rdata=%h want 10 %h",
                     {rvalid1, rvalid0}, rdata, ref_mem[2]);
        end
        drive(1, 1'b0, 1'b0, '0, '0);
        last_rdata = ref_mem[2];
        last_win   = 1'b1;
    endtask

    task automatic test_write_only();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int k = 0; k < 6; k++) begin
            a = AW'($urandom_range(0, 63));
            d = $urandom;
            drive(k % 2, 1'b1, 1'b1, a, d);
            @(negedge clk);
            n_cmp++;
            if ({gnt1, gnt0} !== ((k % 2 == 0) ? 2'b01 : 2'b10) ||
                {mem_read, mem_write, mem_addr, mem_wdata} !== {2'b01, a, d}) begin
                n_bad++;
                $display("FAIL wo_access[%0d]: got gnt=%b rd/wr=%b addr=%0d data=%h want port %0d 01 %0d %h",
                         k, {gnt1, gnt0}, {mem_read, mem_write}, mem_addr, mem_wdata, k % 2, a, d);
            end
            ref_mem[a] = d;
            last_win   = 1'(k % 2);
            for (int j = 0; j < 2; j++) begin
                n_cmp++;
                if ({rvalid1, rvalid0} !== 2'b00 || rdata !== last_rdata) begin
                    n_bad++;
                    $display("FAIL wo_rdata[%0d.%0d]: got rvalid=%b rdata=%h want 00 %h",
                             k, j, {rvalid1, rvalid0}, rdata, last_rdata);
                end
                if (j == 0) begin
                    @(negedge clk);
                    drive(k % 2, 1'b0, 1'b0, '0, '0);
                end
            end
        end
    endtask

    task automatic test_reset_in_access();
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 6'd63, '0);
        @(negedge clk);
        n_cmp++;
        if ({gnt1, gnt0, mem_read} !== 3'b011) begin
            n_bad++;
            $display("FAIL rst_pre: got gnt=%b rd=%b want 01 1", {gnt1, gnt0}, mem_read);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_win   = 1'b1;
        last_rdata = '0;
        n_cmp++;
        if ({gnt1, gnt0, rvalid1, rvalid0, mem_read, mem_write} !== 6'b0 || rdata !== '0) begin
            n_bad++;
            $display("FAIL rst_in_access: got gnt=%b rv=%b rd/wr=%b rdata=%h want all 0",
                     {gnt1, gnt0}, {rvalid1, rvalid0}, {mem_read, mem_write}, rdata);
        end
        // without the reset port 1 would win this tie; after it, port 0 must
        drive(0, 1'b1, 1'b0, 6'd5, '0);
        drive(1, 1'b1, 1'b0, 6'd6, '0);
        @(negedge clk);
        n_cmp++;
        if ({gnt1, gnt0} !== 2'b01) begin
            n_bad++;
            $display("FAIL rst_ptr: got %b want 01", {gnt1, gnt0});
        end
        @(negedge clk);
        n_cmp++;
        if ({rvalid1, rvalid0} !== 2'b01 || rdata !== ref_mem[5]) begin
            n_bad++;
            $display("FAIL rst_post_rd: got rvalid=%b rdata=%h want 01 %h",
                     {rvalid1, rvalid0}, rdata, ref_mem[5]);
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, '0, '0);
        last_win   = 1'b1;
        last_rdata = ref_mem[6];
    endtask

    task automatic test_random_traffic();
        logic          r [2];
        logic          t_we [2];
        logic [AW-1:0] t_a [2];
        logic [DW-1:0] t_d [2];
        logic          release_p [2];
        int            waitc [2];
        logic          rl [2];
        logic          prev_g, win, pend, pend_p, nx_pend, nx_pend_p;
        logic [DW-1:0] pend_d, nx_pend_d;
        logic [1:0]    exp_g, exp_rv;
        apply_reset(2);
        for (int p = 0; p < 2; p++) begin
            r[p] = 1'b0; t_we[p] = 1'b0; t_a[p] = '0; t_d[p] = '0;
            release_p[p] = 1'b0; waitc[p] = 0; rl[p] = 1'b0;
        end
        prev_g = 1'b0; pend = 1'b0; pend_p = 1'b0; pend_d = '0; win = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) if (r[p]) waitc[p]++;
            // an access takes two cycles: a grant is due whenever the previous
            // cycle was not itself a grant and someone was requesting
            exp_g = 2'b00;
            nx_pend = 1'b0; nx_pend_p = 1'b0; nx_pend_d = '0;
            if (!prev_g && (rl[0] || rl[1])) begin
                win   = (rl[0] && rl[1]) ? ~last_win : rl[1];
                exp_g = win ? 2'b10 : 2'b01;
            end
            n_cmp++;
            if ({gnt1, gnt0} !== exp_g) begin
                n_bad++;
                $display("FAIL rnd_gnt[%0d]: got %b want %b", c, {gnt1, gnt0}, exp_g);
            end
            if (exp_g != 2'b00) begin
                n_cmp++;
                if ({mem_read, mem_write, mem_addr} !== {~t_we[win], t_we[win], t_a[win]} ||
                    (t_we[win] && mem_wdata !== t_d[win])) begin
                    n_bad++;
                    $display("FAIL rnd_cmd[%0d]: got rd/wr=%b addr=%0d data=%h want we=%b addr=%0d data=%h",
                             c, {mem_read, mem_write}, mem_addr, mem_wdata, t_we[win], t_a[win], t_d[win]);
                end
                n_cmp++;
                if (waitc[win] > 4) begin
                    n_bad++;
                    $display("FAIL rnd_wait[%0d]: got %0d cycles want <=4", c, waitc[win]);
                end
                if (t_we[win]) begin
                    ref_mem[t_a[win]] = t_d[win];
                end else begin
                    nx_pend = 1'b1; nx_pend_p = win; nx_pend_d = ref_mem[t_a[win]];
                end
                last_win = win;
            end else begin
                n_cmp++;
                if ({mem_read, mem_write} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL rnd_strobe[%0d]: got %b want 00", c, {mem_read, mem_write});
                end
            end
            exp_rv = 2'b00;
            if (pend) begin
                exp_rv     = pend_p ? 2'b10 : 2'b01;
                last_rdata = pend_d;
            end
            n_cmp++;
            if ({rvalid1, rvalid0} !== exp_rv || rdata !== last_rdata) begin
                n_bad++;
                $display("FAIL rnd_rdata[%0d]: got rvalid=%b rdata=%h want %b %h",
                         c, {rvalid1, rvalid0}, rdata, exp_rv, last_rdata);
            end
            pend = nx_pend; pend_p = nx_pend_p; pend_d = nx_pend_d;
            prev_g = (exp_g != 2'b00);
            // requesters: release one cycle after their grant, then maybe re-request
            for (int p = 0; p < 2; p++) begin
                if (release_p[p]) begin
                    r[p] = 1'b0;
                    release_p[p] = 1'b0;
                end
                if (!r[p] && c < 390 && $urandom_range(0, 1) == 1) begin
                    r[p]    = 1'b1;
                    t_we[p] = 1'($urandom_range(0, 1));
                    t_a[p]  = AW'($urandom_range(0, 63));
                    t_d[p]  = $urandom;
                    waitc[p] = 0;
                end
                if (exp_g != 2'b00 && win == 1'(p)) release_p[p] = 1'b1;
                drive(p, r[p], t_we[p], t_a[p], t_d[p]);
                rl[p] = r[p];
            end
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_contention();
        test_port1_solo();
        test_write_only();
        test_reset_in_access();
        test_random_traffic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
